ttl_74161_chain: RTL and testbench

Synchronous cascade of 74161-style 4-bit binary counters, modelled in the FPGA clock domain and gated by a board-clock enable strobe. It generates the select and enable lines that drive the ttl_74155 dual 2-to-4 decoders in the video and CPU timing chains. Typical connections are low Q bits to the decoder A inputs and RCO or high Q bits to Enable1C or Enable2C_bar. The block is cycle-exact to the board: one count step per cen strobe, with lookahead carry between stages.

---
 rtl/ttl_74161_chain_pkg.sv | 43 ++++
 rtl/ttl_74161_cell.sv | 44 ++++
 rtl/ttl_74161_chain.sv | 61 ++++++
 tb/tb_ttl_74161_chain.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/ttl_74161_chain_pkg.sv
// Shared constants, per-stage operation decode and the bus-packing macro
// for the ttl_74161_chain counter cascade.
package ttl_74161_chain_pkg;

  localparam int unsigned STAGE_WIDTH = 4;

  // Action one counter stage takes on a clk rising edge
  typedef enum logic [2:0] {
    OP_HOLD,
    OP_RESET,
    OP_CLEAR,
    OP_LOAD,
    OP_COUNT
  } stage_op_e;

  // Priority: reset, clear (no cen needed), load, count, hold
  function automatic stage_op_e stage_op(
    input logic reset,
    input logic clear_bar,
    input logic cen,
    input logic load_bar,
    input logic enp,
    input logic ent
  );
    stage_op_e op;
    if (reset)                   op = OP_RESET;
    else if (!clear_bar)         op = OP_CLEAR;
    else if (cen && !load_bar)   op = OP_LOAD;
    else if (cen && enp && ent)  op = OP_COUNT;
    else                         op = OP_HOLD;
    return op;
  endfunction

endpackage

`ifndef TTL_74161_PACK_ARRAY
`define TTL_74161_PACK_ARRAY
// Flattens unpacked array SRC[COUNT] of WIDTH-bit words onto packed bus DST
`define PACK_ARRAY(WIDTH, COUNT, SRC, DST) \
  for (genvar pk_i = 0; pk_i < (COUNT); pk_i++) begin : g_pack \
    assign DST[(WIDTH)*pk_i +: (WIDTH)] = SRC[pk_i]; \
  end
`endif

// File: rtl/ttl_74161_cell.sv
// One 74161-style 4-bit synchronous counter stage in the FPGA clock domain.
module ttl_74161_cell
  import ttl_74161_chain_pkg::*;
#(
  parameter logic [STAGE_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cen,
  input  logic                   Clear_bar,
  input  logic                   Load_bar,
  input  logic                   ENP,
  input  logic                   ENT,
  input  logic [STAGE_WIDTH-1:0] D,
  output logic [STAGE_WIDTH-1:0] Q,
  output logic                   RCO
);

  stage_op_e                op;
  logic [STAGE_WIDTH-1:0]   q_reg;

  // Decode which action applies on the coming edge
  always_comb begin
    op = stage_op(reset, Clear_bar, cen, Load_bar, ENP, ENT);
  end

  // Stage register: reset, clear, load, count or hold
  always_ff @(posedge clk) begin
    case (op)
      OP_RESET: q_reg <= RESET_VALUE;
      OP_CLEAR: q_reg <= '0;
      OP_LOAD:  q_reg <= D;
      OP_COUNT: q_reg <= q_reg + 4'd1;
      default:  q_reg <= q_reg;
    endcase
  end

  // Carry out from registered value and live ENT; ENP does not gate it
  always_comb begin
    Q   = q_reg;
    RCO = ENT && (q_reg == '1);
  end

endmodule

// File: rtl/ttl_74161_chain.sv
// Cascade of 74161-style counters with lookahead carry, stepped by cen.
// Drives select/enable lines of the ttl_74155 decoders in the timing chains.
module ttl_74161_chain
  import ttl_74161_chain_pkg::*;
#(
  parameter int unsigned                     STAGES      = 2,
  parameter logic [STAGE_WIDTH*STAGES-1:0]   RESET_VALUE = '0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cen,
  input  logic                            Clear_bar,
  input  logic                            Load_bar,
  input  logic                            ENP,
  input  logic                            ENT,
  input  logic [STAGE_WIDTH*STAGES-1:0]   D,
  output logic [STAGE_WIDTH*STAGES-1:0]   Q,
  output logic [STAGES-1:0]               RCO,
  output logic                            TC
);

  logic [STAGE_WIDTH-1:0] q_stage [STAGES];
  logic [STAGES-1:0]      ent_stage;
  logic [STAGES-1:0]      rco_stage;

  // Lookahead carry: every stage sees its enable from the combinational
  // RCO of the stage below, so all stages step on the same edge.
  always_comb begin
    ent_stage = '0;
    ent_stage[0] = ENT;
    for (int unsigned k = 1; k < STAGES; k++) begin
      ent_stage[k] = rco_stage[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    ttl_74161_cell #(
      .RESET_VALUE (RESET_VALUE[STAGE_WIDTH*k +: STAGE_WIDTH])
    ) u_cell (
      .clk       (clk),
      .reset     (reset),
      .cen       (cen),
      .Clear_bar (Clear_bar),
      .Load_bar  (Load_bar),
      .ENP       (ENP),
      .ENT       (ent_stage[k]),
      .D         (D[STAGE_WIDTH*k +: STAGE_WIDTH]),
      .Q         (q_stage[k]),
      .RCO       (rco_stage[k])
    );
  end

  `PACK_ARRAY(STAGE_WIDTH, STAGES, q_stage, Q)

  // Carry outputs are purely combinational from the stage chain
  always_comb begin
    RCO = rco_stage;
    TC  = rco_stage[STAGES-1];
  end

endmodule

// File: tb/tb_ttl_74161_chain.sv
// Self-checking bench: directed board scenarios then random stimulus,
// compared against an integer-arithmetic model of the counter chain.
module tb_ttl_74161_chain;

  localparam int unsigned S   = 2;
  localparam int unsigned W   = 4 * S;
  localparam int          MOD = 1 << W;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, cen, Clear_bar, Load_bar, ENP, ENT;
  logic [W-1:0] D;
  logic [W-1:0] q0, q1;
  logic [S-1:0] rco0, rco1;
  logic         tc0, tc1;

  int n_vec = 0;
  int n_err = 0;
  int m0, m1;

  ttl_74161_chain #(.STAGES(S), .RESET_VALUE(8'h00)) dut (
    .clk(clk), .reset(reset), .cen(cen), .Clear_bar(Clear_bar),
    .Load_bar(Load_bar), .ENP(ENP), .ENT(ENT), .D(D),
    .Q(q0), .RCO(rco0), .TC(tc0)
  );

  ttl_74161_chain #(.STAGES(S), .RESET_VALUE(8'h0F)) dut_rv (
    .clk(clk), .reset(reset), .cen(cen), .Clear_bar(Clear_bar),
    .Load_bar(Load_bar), .ENP(ENP), .ENT(ENT), .D(D),
    .Q(q1), .RCO(rco1), .TC(tc1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Chain value as one integer: stage k carries when everything below it is all ones
  function automatic logic [S-1:0] exp_rco(input int m, input logic ent);
    logic [S-1:0] r;
    int span;
    r = '0;
    for (int k = 0; k < S; k++) begin
      span = 1 << (4 * (k + 1));
      r[k] = ent && ((m % span) == span - 1);
    end
    return r;
  endfunction

  function automatic int next_val(input int m, input int rv);
    if (reset)                     return rv;
    else if (!Clear_bar)           return 0;
    else if (cen && !Load_bar)     return int'(D);
    else if (cen && ENP && ENT)    return (m + 1) % MOD;
    else                           return m;
  endfunction

  task automatic check_all(input string tag);
    logic [S-1:0] e0, e1;
    e0 = exp_rco(m0, ENT);
    e1 = exp_rco(m1, ENT);
    check_eq({tag, "_q"},    32'(q0),   32'(m0));
    check_eq({tag, "_rco"},  32'(rco0), 32'(e0));
    check_eq({tag, "_tc"},   32'(tc0),  32'(e0[S-1]));
    check_eq({tag, "_qrv"},  32'(q1),   32'(m1));
    check_eq({tag, "_rcorv"},32'(rco1), 32'(e1));
    check_eq({tag, "_tcrv"}, 32'(tc1),  32'(e1[S-1]));
  endtask

  task automatic tick(input int unsigned n, input string tag);
    repeat (n) begin
      @(posedge clk);
      m0 = next_val(m0, 'h00);
      m1 = next_val(m1, 'h0F);
      #1;
      check_all(tag);
    end
  endtask

  task automatic load(input logic [W-1:0] val);
    D = val; Load_bar = 1'b0; cen = 1'b1;
    tick(1, "load");
    Load_bar = 1'b1; cen = 1'b0;
  endtask

  initial begin
    m0 = 0; m1 = 0;
    reset = 1'b1; Clear_bar = 1'b1; Load_bar = 1'b1; cen = 1'b0;
    ENP = 1'b0; ENT = 1'b0; D = '0;

    // Reset held two clocks
    tick(2, "reset");
    check_eq("reset_q_const", 32'(q0), 32'h00);
    check_eq("reset_tc_const", 32'(tc0), 32'h0);
    reset = 1'b0;

    // Three spaced strobes, value steady between them
    ENP = 1'b1; ENT = 1'b1;
    repeat (3) begin
      cen = 1'b1; tick(1, "strobe");
      cen = 1'b0; tick(3, "steady");
    end
    check_eq("count3", 32'(q0), 32'h03);

    // Stage carry
    load(8'h0E);
    cen = 1'b1; tick(1, "carry_a");
    check_eq("carry_0f", 32'(q0), 32'h0F);
    check_eq("carry_rco0", 32'(rco0[0]), 32'h1);
    tick(1, "carry_b");
    check_eq("carry_10", 32'(q0), 32'h10);
    check_eq("carry_rco0_lo", 32'(rco0[0]), 32'h0);

    // ENP low holds, RCO still shows terminal count; ENT low drops it at once
    load(8'h0F);
    ENP = 1'b0; cen = 1'b1; tick(1, "enp_hold");
    check_eq("enp_hold_q", 32'(q0), 32'h0F);
    check_eq("enp_hold_rco", 32'(rco0[0]), 32'h1);
    ENT = 1'b0; cen = 1'b0; #1;
    check_all("ent_low");
    check_eq("ent_low_rco", 32'(rco0[0]), 32'h0);

    // Clear without cen, then clear beats load
    load(8'h5A);
    Clear_bar = 1'b0; tick(1, "clear");
    check_eq("clear_q", 32'(q0), 32'h00);
    Clear_bar = 1'b1; load(8'h44);
    D = 8'h33; Clear_bar = 1'b0; Load_bar = 1'b0; cen = 1'b1;
    tick(1, "clear_vs_load");
    check_eq("clear_wins", 32'(q0), 32'h00);
    Clear_bar = 1'b1; Load_bar = 1'b1; cen = 1'b0;

    // Full wrap
    load(8'hFE);
    ENP = 1'b1; ENT = 1'b1; cen = 1'b1;
    tick(1, "wrap_a");
    check_eq("wrap_ff_tc", 32'(tc0), 32'h1);
    tick(1, "wrap_b");
    check_eq("wrap_00", 32'(q0), 32'h00);
    check_eq("wrap_tc_lo", 32'(tc0), 32'h0);

    // Reset mid-count on a cen cycle
    load(8'h27);
    cen = 1'b1; tick(1, "run");
    reset = 1'b1; tick(1, "reset_mid");
    check_eq("reset_mid_rv", 32'(q1), 32'h0F);
    check_eq("reset_mid_rco", 32'(rco1[0]), 32'h1);
    reset = 1'b0; cen = 1'b0;

    // Random phase
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 49) == 0);
      Clear_bar = ($urandom_range(0, 19) != 0);
      Load_bar  = ($urandom_range(0, 7) != 0);
      cen       = ($urandom_range(0, 1) == 1);
      ENP       = ($urandom_range(0, 3) != 0);
      ENT       = ($urandom_range(0, 3) != 0);
      D         = W'($urandom);
      tick(1, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
